// File: rtl/heartbeat_monitor.sv
`default_nettype none
// ============================================================================
// Module  : heartbeat_monitor
// Brief   : Multi-channel beat tracker with sticky fast/slow interval alarms
//           and last measured inter-beat gap per channel.
// Revision: 1.0 - initial release
// ============================================================================
module heartbeat_monitor #(
  parameter int NCH      = 2,
  parameter int CNT_BITS = 4,
  parameter int MIN_GAP  = 3,
  parameter int MAX_GAP  = 6
) (
  input  logic                    clk_2,
  input  logic                    reset,
  input  logic [NCH-1:0]          beat,
  input  logic [NCH-1:0]          enable,
  input  logic                    clear,
  output logic [NCH-1:0]          present,
  output logic [NCH-1:0]          fast_alarm,
  output logic [NCH-1:0]          slow_alarm,
  output logic                    any_alarm,
  output logic [NCH*CNT_BITS-1:0] last_gap
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  localparam logic [CNT_BITS-1:0] c_cnt_max = '1;
  localparam logic [CNT_BITS-1:0] c_min_gap = CNT_BITS'(MIN_GAP);
  localparam logic [CNT_BITS-1:0] c_max_gap = CNT_BITS'(MAX_GAP);

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      state_t              r_state;
      state_t              w_state_nxt;
      logic [CNT_BITS-1:0] r_cnt;
      logic [CNT_BITS-1:0] w_cnt_nxt;
      logic [CNT_BITS-1:0] w_cnt_inc;
      logic [CNT_BITS-1:0] r_gap;
      logic [CNT_BITS-1:0] w_gap_nxt;
      logic                r_beat_q;
      logic                r_fast;
      logic                r_slow;
      logic                w_fast_nxt;
      logic                w_slow_nxt;
      logic                w_evt;

      assign w_evt     = beat[i] & ~r_beat_q & enable[i];
      assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;

      // Clear is folded into the hold value so a same-cycle set still wins.
      always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_inc;
        w_gap_nxt   = r_gap;
        w_fast_nxt  = r_fast & ~clear;
        w_slow_nxt  = r_slow & ~clear;
        if (!enable[i]) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              if (w_evt) begin
                w_state_nxt = ST_TRACK;
                w_cnt_nxt   = '0;
              end
            end
            ST_TRACK: begin
              if (w_evt) begin
                w_gap_nxt = r_cnt;
                w_cnt_nxt = '0;
                if (r_cnt < c_min_gap) begin
                  w_fast_nxt = 1'b1;
                end
              end else if (r_cnt == c_max_gap) begin
                w_state_nxt = ST_IDLE;
                w_slow_nxt  = 1'b1;
              end
            end
            default: w_state_nxt = ST_IDLE;
          endcase
        end
      end

      always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
          r_state  <= ST_IDLE;
          r_cnt    <= '0;
          r_gap    <= '0;
          r_beat_q <= 1'b0;
          r_fast   <= 1'b0;
          r_slow   <= 1'b0;
        end else begin
          r_state  <= w_state_nxt;
          r_cnt    <= w_cnt_nxt;
          r_gap    <= w_gap_nxt;
          r_beat_q <= beat[i];
          r_fast   <= w_fast_nxt;
          r_slow   <= w_slow_nxt;
        end
      end

      assign present[i]                        = (r_state == ST_TRACK);
      assign fast_alarm[i]                     = r_fast;
      assign slow_alarm[i]                     = r_slow;
      assign last_gap[i*CNT_BITS +: CNT_BITS]  = r_gap;
    end
  endgenerate

  assign any_alarm = |{fast_alarm, slow_alarm};

endmodule
`default_nettype wire

// File: tb/tb_heartbeat_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tb_heartbeat_monitor
// Brief   : Directed and randomized checks of heartbeat_monitor against a
//           timestamp-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_heartbeat_monitor;
  localparam int NCH  = 2;
  localparam int CB   = 4;
  localparam int MING = 3;
  localparam int MAXG = 6;
  localparam int CMAX = 15;

  logic           clk_2 = 1'b0;
  logic           reset;
  logic [NCH-1:0] beat;
  logic [NCH-1:0] enable;
  logic           clear;
  logic [NCH-1:0] present;
  logic [NCH-1:0] fast_alarm;
  logic [NCH-1:0] slow_alarm;
  logic           any_alarm;
  logic [NCH*CB-1:0] last_gap;

  heartbeat_monitor #(
    .NCH(NCH), .CNT_BITS(CB), .MIN_GAP(MING), .MAX_GAP(MAXG)
  ) dut (
    .clk_2(clk_2), .reset(reset), .beat(beat), .enable(enable), .clear(clear),
    .present(present), .fast_alarm(fast_alarm), .slow_alarm(slow_alarm),
    .any_alarm(any_alarm), .last_gap(last_gap)
  );

  always #5 clk_2 = ~clk_2;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each channel remembers the edge at which its counter last restarted;
  // the counter value is just elapsed edges, capped at CMAX.
  int             cyc;
  bit             m_q[NCH];
  bit             m_trk[NCH];
  int             m_ref[NCH];
  logic [NCH-1:0] m_fast;
  logic [NCH-1:0] m_slow;
  logic [NCH*CB-1:0] m_gap;

  task automatic model_reset();
    cyc    = 0;
    m_fast = '0;
    m_slow = '0;
    m_gap  = '0;
    for (int i = 0; i < NCH; i++) begin
      m_q[i]   = 1'b0;
      m_trk[i] = 1'b0;
      m_ref[i] = 0;
    end
  endtask

  always @(posedge clk_2) begin
    if (!reset) begin
      logic [NCH-1:0] m_pres;
      cyc++;
      for (int i = 0; i < NCH; i++) begin
        int cnt;
        bit evt, fset, sset;
        cnt  = cyc - 1 - m_ref[i];
        if (cnt > CMAX) cnt = CMAX;
        evt  = beat[i] && !m_q[i] && enable[i];
        fset = 1'b0;
        sset = 1'b0;
        if (!enable[i]) begin
          m_trk[i] = 1'b0;
          m_ref[i] = cyc;
        end else if (evt) begin
          if (m_trk[i]) begin
            m_gap[i*CB +: CB] = CB'(cnt);
            fset = (cnt < MING);
          end
          m_trk[i] = 1'b1;
          m_ref[i] = cyc;
        end else if (m_trk[i] && cnt == MAXG) begin
          m_trk[i] = 1'b0;
          sset = 1'b1;
        end
        m_fast[i] = (m_fast[i] & ~clear) | fset;
        m_slow[i] = (m_slow[i] & ~clear) | sset;
        m_q[i]    = beat[i];
      end
      for (int i = 0; i < NCH; i++) m_pres[i] = m_trk[i];
      #1;
      chk("present", 32'(present), 32'(m_pres));
      chk("fast_alarm", 32'(fast_alarm), 32'(m_fast));
      chk("slow_alarm", 32'(slow_alarm), 32'(m_slow));
      chk("any_alarm", 32'(any_alarm), 32'(|{m_fast, m_slow}));
      chk("last_gap", 32'(last_gap), 32'(m_gap));
    end
  end

  task automatic step(input logic [NCH-1:0] b, input logic [NCH-1:0] e, input logic c);
    beat   = b;
    enable = e;
    clear  = c;
    @(posedge clk_2);
    #2;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_present"}, 32'(present), 32'd0);
    chk({nm, "_fast"}, 32'(fast_alarm), 32'd0);
    chk({nm, "_slow"}, 32'(slow_alarm), 32'd0);
    chk({nm, "_any"}, 32'(any_alarm), 32'd0);
    chk({nm, "_gap"}, 32'(last_gap), 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    beat   = '0;
    enable = '0;
    clear  = 1'b0;
    model_reset();
    #3;
    chk_all_zero("reset");
    @(negedge clk_2);
    reset = 1'b0;

    step(2'b00, 2'b11, 1'b0);
    // period-5 pulses on channel 0
    step(2'b01, 2'b11, 1'b0);
    chk("lock_present", 32'(present), 32'h1);
    repeat (4) step(2'b00, 2'b11, 1'b0);
    step(2'b01, 2'b11, 1'b0);
    chk("p5_gap", 32'(last_gap[3:0]), 32'd4);
    chk("p5_alarms", 32'({fast_alarm, slow_alarm}), 32'd0);
    chk("p5_ch1_idle", 32'(present), 32'h1);
    repeat (4) step(2'b00, 2'b11, 1'b0);
    step(2'b01, 2'b11, 1'b0);
    chk("p5_gap2", 32'(last_gap[3:0]), 32'd4);

    // period 3 is fast
    repeat (2) step(2'b00, 2'b11, 1'b0);
    step(2'b01, 2'b11, 1'b0);
    chk("p3_fast", 32'(fast_alarm), 32'h1);
    chk("p3_gap", 32'(last_gap[3:0]), 32'd2);
    chk("p3_any", 32'(any_alarm), 32'd1);
    chk("p3_present", 32'(present), 32'h1);

    // clear alone, then clear colliding with a period-2 beat
    step(2'b00, 2'b11, 1'b1);
    chk("clr_fast", 32'(fast_alarm), 32'h0);
    chk("clr_any", 32'(any_alarm), 32'd0);
    step(2'b01, 2'b11, 1'b1);
    chk("clr_set_wins", 32'(fast_alarm), 32'h1);
    chk("p2_gap", 32'(last_gap[3:0]), 32'd1);

    // loss after silence: event edge e, loss at e+7
    step(2'b00, 2'b11, 1'b1);
    repeat (5) step(2'b00, 2'b11, 1'b0);
    chk("pre_loss_present", 32'(present), 32'h1);
    chk("pre_loss_slow", 32'(slow_alarm), 32'h0);
    step(2'b00, 2'b11, 1'b0);
    chk("loss_present", 32'(present), 32'h0);
    chk("loss_slow", 32'(slow_alarm), 32'h1);
    repeat (20) step(2'b00, 2'b11, 1'b0);
    chk("sat_slow_sticky", 32'(slow_alarm), 32'h1);
    chk("sat_gap_hold", 32'(last_gap[3:0]), 32'd1);

    // disable mid-TRACK
    step(2'b00, 2'b11, 1'b1);
    step(2'b01, 2'b11, 1'b0);
    chk("relock_present", 32'(present), 32'h1);
    chk("relock_nofast", 32'(fast_alarm), 32'h0);
    step(2'b00, 2'b10, 1'b0);
    chk("dis_present", 32'(present), 32'h0);
    step(2'b01, 2'b10, 1'b0);
    step(2'b00, 2'b10, 1'b0);
    step(2'b01, 2'b10, 1'b0);
    chk("dis_ignored", 32'({present, fast_alarm, slow_alarm}), 32'd0);
    step(2'b00, 2'b11, 1'b0);
    step(2'b01, 2'b11, 1'b0);
    chk("reen_present", 32'(present), 32'h1);
    chk("reen_nofast", 32'(fast_alarm), 32'h0);

    // both channels on one edge, periods 2 and 5
    step(2'b00, 2'b11, 1'b0);
    step(2'b11, 2'b11, 1'b0);
    step(2'b00, 2'b11, 1'b0);
    step(2'b00, 2'b11, 1'b0);
    step(2'b01, 2'b11, 1'b0);
    step(2'b00, 2'b11, 1'b1);
    step(2'b11, 2'b11, 1'b0);
    chk("dual_fast", 32'(fast_alarm), 32'h1);
    chk("dual_slow", 32'(slow_alarm), 32'h0);
    chk("dual_gap", 32'(last_gap), 32'h41);
    chk("dual_present", 32'(present), 32'h3);

    // asynchronous reset mid-TRACK
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    chk_all_zero("async_rst");
    beat   = 2'b11;
    enable = 2'b11;
    @(negedge clk_2);
    reset = 1'b0;
    step(2'b11, 2'b11, 1'b0);
    chk("held_beat_evt", 32'(present), 32'h3);
    chk("held_beat_noalarm", 32'(any_alarm), 32'd0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [NCH-1:0] b, e;
      logic c;
      for (int i = 0; i < NCH; i++) begin
        b[i] = ($urandom_range(0, 99) < 35);
        e[i] = ($urandom_range(0, 29) != 0);
      end
      c = ($urandom_range(0, 15) == 0);
      step(b, e, c);
      if (n == 300) begin
        reset = 1'b1;
        model_reset();
        #1;
        chk_all_zero("rand_rst");
        @(negedge clk_2);
        reset = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/heartbeat_monitor.md
# heartbeat_monitor

Parametrised multi-channel heartbeat monitor. Each channel watches a beat input, tracks whether a pulse is present, and raises sticky "too fast" and "too slow/lost" alarms against programmable minimum and maximum beat intervals. It also reports the last measured inter-beat gap. It sits behind the board switch inputs and drives the LED/LCD status outputs of the top level.

## Interface
- NCH, 2, number of independent channels
- CNT_BITS, 4, width of the per-channel gap counter; counter saturates at 2^CNT_BITS-1
- MIN_GAP, 3, smallest legal gap count; a beat with gap count < MIN_GAP is "fast"
- MAX_GAP, 6, largest gap count tolerated before the pulse is declared lost
- Legal parameters: 0 < MIN_GAP < MAX_GAP < 2^CNT_BITS-1
- clk_2  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clock clk_2
- beat  input  NCH  per-channel beat level; a beat event is a 0→1 transition
- enable  input  NCH  per-channel enable; 0 holds the channel idle
- clear  input  1  synchronous clear of all sticky alarms
- present  output  NCH  1 while the channel is in TRACK
- fast_alarm  output  NCH  sticky; beat arrived too early
- slow_alarm  output  NCH  sticky; pulse lost (gap exceeded MAX_GAP)
- any_alarm  output  1  OR of all fast_alarm and slow_alarm bits
- last_gap  output  NCH*CNT_BITS  gap count at the latest accepted beat; channel i occupies bits [i*CNT_BITS +: CNT_BITS]

## Operation
- Per channel: beat_q register; beat_evt = beat & ~beat_q & enable.
- Per channel: cnt counts cycles since the last event; it increments and saturates at 2^CNT_BITS-1.
- Per channel FSM with two states, IDLE and TRACK. present = (state == TRACK).
- IDLE, beat_evt: go to TRACK; cnt←0; no alarm; last_gap unchanged.
- IDLE, no event: stay in IDLE; cnt saturating +1.
- TRACK, beat_evt with cnt < MIN_GAP: set fast_alarm; last_gap←cnt; cnt←0; stay in TRACK.
- TRACK, beat_evt with cnt ≥ MIN_GAP: last_gap←cnt; cnt←0; stay in TRACK.
- TRACK, no event, cnt == MAX_GAP: go to IDLE; set slow_alarm; cnt←cnt+1.
- TRACK, no event, cnt < MAX_GAP: cnt+1.
- enable[i]=0: state←IDLE, cnt←0, no alarm set. beat_q still samples beat. Existing alarms and last_gap hold.
- clear=1: all fast_alarm and slow_alarm bits ←0. If a set condition occurs in the same cycle, the set wins and the bit remains 1.
- Channels are fully independent. Simultaneous events on several channels are all processed in the same cycle.

## Timing
- Reset values: state IDLE, cnt 0, beat_q 0, present 0, fast_alarm 0, slow_alarm 0, any_alarm 0, last_gap 0.
- beat_q resets to 0, so beat held high through reset release yields one event at the first clock edge.
- All outputs are registered except any_alarm, which is combinational from the alarm registers.
- An event is sampled at edge t. present, fast_alarm and last_gap update at edge t and are visible after it, so latency is 1 cycle from beat rising before edge t.
- If beats occur at edges t and t+P, the second beat sees cnt = P-1. A beat is fast iff P-1 < MIN_GAP.
- Loss: if the last event was at edge t with no further event, present falls and slow_alarm rises at edge t+MAX_GAP+1.
- Reset asserted mid-TRACK returns every register to its reset value immediately, without waiting for a clock edge.

## Test plan
- Reset, enable=2'b11, beat0 pulses for 1 cycle every 5 cycles → present0=1 after first event; last_gap[3:0]=4; no alarms; channel 1 stays present=0.
- beat0 period 3 after lock → fast_alarm0=1 at the second beat edge; last_gap=2; any_alarm=1; present0 stays 1.
- Single beat0, then silence → present0 falls and slow_alarm0=1 exactly 7 edges after the event edge; cnt saturates at 15 with no wrap.
- clear pulsed alone → alarms go to 0. clear pulsed in the same cycle as a period-2 beat → fast_alarm0 remains 1.
- enable0=0 mid-TRACK → present0=0 next edge; beats ignored; no alarms. Re-enable, then beat → TRACK from cnt=0 with no fast alarm.
- Both channels beat on the same edge with periods 2 and 5 → fast_alarm=2'b01; last_gap={4'd4,4'd1}. Assert reset mid-TRACK → all outputs 0 asynchronously.
